// File: rtl/refill_ctrl_pkg.sv
// Shared L1 data-cache definitions: refill FSM states, line geometry constants and width helpers.
// Common to the lookup pipeline, the replacement stage and the refill controller.
package refill_ctrl_pkg;

  localparam int unsigned WORD_WIDTH       = 32;
  localparam int unsigned CACHE_LINE_WORDS = 4;

  typedef enum logic [2:0] {
    StIdle,
    StVictim,
    StWbReq,
    StWbData,
    StFillReq,
    StFillData,
    StCommit
  } refill_state_e;

  function automatic int unsigned line_addr_bits(input int unsigned tag_bits,
                                                 input int unsigned index_bits);
    return tag_bits + index_bits;
  endfunction

  function automatic int unsigned way_bits(input int unsigned num_ways);
    return (num_ways > 1) ? unsigned'($clog2(num_ways)) : 1;
  endfunction

endpackage

// File: rtl/refill_ctrl_if.sv
// Bus bundle between the refill controller and the cache (miss pipe, replacement, arrays, memory).
// master = refill controller side, slave = the surrounding cache/memory side.
interface refill_ctrl_if import refill_ctrl_pkg::*; #(
  parameter int unsigned NUM_SETS   = 64,
  parameter int unsigned NUM_WAYS   = 4,
  parameter int unsigned TAG_BITS   = 20,
  parameter int unsigned LINE_WORDS = CACHE_LINE_WORDS
) ();
  localparam int unsigned INDEX_BITS = $clog2(NUM_SETS);
  localparam int unsigned WAY_BITS   = way_bits(NUM_WAYS);
  localparam int unsigned WORD_BITS  = $clog2(LINE_WORDS);
  localparam int unsigned ADDR_BITS  = line_addr_bits(TAG_BITS, INDEX_BITS);

  logic                  miss_valid;
  logic                  miss_ready;
  logic [INDEX_BITS-1:0] miss_index;
  logic [TAG_BITS-1:0]   miss_tag;
  logic [INDEX_BITS-1:0] repl_index;
  logic [WAY_BITS-1:0]   repl_victim_way;
  logic                  victim_valid;
  logic                  victim_dirty;
  logic [TAG_BITS-1:0]   victim_tag;
  logic                  repl_update_en;
  logic [WAY_BITS-1:0]   repl_update_way;
  logic                  arr_rd_en;
  logic                  arr_wr_en;
  logic [WAY_BITS-1:0]   arr_way;
  logic [WORD_BITS-1:0]  arr_word;
  logic [WORD_WIDTH-1:0] arr_wdata;
  logic [WORD_WIDTH-1:0] arr_rdata;
  logic                  tag_wr_en;
  logic [TAG_BITS-1:0]   tag_wr_tag;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_write;
  logic [ADDR_BITS-1:0]  mem_req_addr;
  logic                  mem_wvalid;
  logic                  mem_wready;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic                  mem_rvalid;
  logic [WORD_WIDTH-1:0] mem_rdata;
  logic                  refill_done;

  modport master (
    input  miss_valid, miss_index, miss_tag, repl_victim_way, victim_valid, victim_dirty,
           victim_tag, arr_rdata, mem_req_ready, mem_wready, mem_rvalid, mem_rdata,
    output miss_ready, repl_index, repl_update_en, repl_update_way, arr_rd_en, arr_wr_en,
           arr_way, arr_word, arr_wdata, tag_wr_en, tag_wr_tag, mem_req_valid, mem_req_write,
           mem_req_addr, mem_wvalid, mem_wdata, refill_done
  );

  modport slave (
    output miss_valid, miss_index, miss_tag, repl_victim_way, victim_valid, victim_dirty,
           victim_tag, arr_rdata, mem_req_ready, mem_wready, mem_rvalid, mem_rdata,
    input  miss_ready, repl_index, repl_update_en, repl_update_way, arr_rd_en, arr_wr_en,
           arr_way, arr_word, arr_wdata, tag_wr_en, tag_wr_tag, mem_req_valid, mem_req_write,
           mem_req_addr, mem_wvalid, mem_wdata, refill_done
  );

endinterface

// File: rtl/refill_beat_ctr.sv
// Word-within-line beat counter shared by the writeback and fill phases.
// Wraps naturally at line end; clear has priority over enable.
module refill_beat_ctr #(
  parameter int unsigned WORD_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  output logic [WORD_BITS-1:0] cnt,
  output logic                 last
);

  logic [WORD_BITS-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt  = cnt_q;
  assign last = &cnt_q;

endmodule

// File: rtl/refill_ctrl.sv
// Per-miss L1D refill controller: optional dirty-victim writeback, line fill, tag install and
// replacement update. One miss in flight at a time.
module refill_ctrl import refill_ctrl_pkg::*; #(
  parameter int unsigned NUM_SETS   = 64,
  parameter int unsigned NUM_WAYS   = 4,
  parameter int unsigned TAG_BITS   = 20,
  parameter int unsigned LINE_WORDS = CACHE_LINE_WORDS
) (
  input logic           clk,
  input logic           rst_n,
  refill_ctrl_if.master bus
);

  localparam int unsigned INDEX_BITS = $clog2(NUM_SETS);
  localparam int unsigned WAY_BITS   = way_bits(NUM_WAYS);
  localparam int unsigned WORD_BITS  = $clog2(LINE_WORDS);

  refill_state_e         state_q, state_d;
  logic [INDEX_BITS-1:0] index_q;
  logic [TAG_BITS-1:0]   tag_q, victim_tag_q;
  logic [WAY_BITS-1:0]   way_q;
  logic                  beat_out_q, beat_out_d;
  logic                  fresh_q, fresh_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0] wb_data;
  logic                  ctr_clr, ctr_en, ctr_last;
  logic [WORD_BITS-1:0]  ctr_cnt;

  assign ctr_clr = (state_d != state_q);

  refill_beat_ctr #(
    .WORD_BITS(WORD_BITS)
  ) u_beat_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (ctr_clr),
    .en   (ctr_en),
    .cnt  (ctr_cnt),
    .last (ctr_last)
  );

  // Array read data is live only in the first cycle of a beat; later stall cycles replay wdata_q.
  assign wb_data = fresh_q ? bus.arr_rdata : wdata_q;

  always_comb begin
    state_d             = state_q;
    beat_out_d          = beat_out_q;
    fresh_d             = 1'b0;
    wdata_d             = wdata_q;
    ctr_en              = 1'b0;
    bus.miss_ready      = (state_q == StIdle);
    bus.repl_index      = index_q;
    bus.repl_update_en  = 1'b0;
    bus.repl_update_way = way_q;
    bus.arr_rd_en       = 1'b0;
    bus.arr_wr_en       = 1'b0;
    bus.arr_way         = way_q;
    bus.arr_word        = ctr_cnt;
    bus.arr_wdata       = bus.mem_rdata;
    bus.tag_wr_en       = 1'b0;
    bus.tag_wr_tag      = tag_q;
    bus.mem_req_valid   = 1'b0;
    bus.mem_req_write   = 1'b0;
    bus.mem_req_addr    = {tag_q, index_q};
    bus.mem_wvalid      = 1'b0;
    bus.mem_wdata       = wdata_q;
    bus.refill_done     = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.miss_valid) state_d = StVictim;
      end
      StVictim: begin
        state_d = (bus.victim_valid && bus.victim_dirty) ? StWbReq : StFillReq;
      end
      StWbReq: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_write = 1'b1;
        bus.mem_req_addr  = {victim_tag_q, index_q};
        if (bus.mem_req_ready) state_d = StWbData;
      end
      StWbData: begin
        if (!beat_out_q) begin
          bus.arr_rd_en = 1'b1;
          beat_out_d    = 1'b1;
          fresh_d       = 1'b1;
        end else begin
          bus.mem_wvalid = 1'b1;
          bus.mem_wdata  = wb_data;
          wdata_d        = wb_data;
          if (bus.mem_wready) begin
            beat_out_d = 1'b0;
            ctr_en     = 1'b1;
            if (ctr_last) state_d = StFillReq;
          end
        end
      end
      StFillReq: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_d = StFillData;
      end
      StFillData: begin
        if (bus.mem_rvalid) begin
          bus.arr_wr_en = 1'b1;
          ctr_en        = 1'b1;
          if (ctr_last) state_d = StCommit;
        end
      end
      StCommit: begin
        bus.tag_wr_en      = 1'b1;
        bus.repl_update_en = 1'b1;
        bus.refill_done    = 1'b1;
        state_d            = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      index_q      <= '0;
      tag_q        <= '0;
      victim_tag_q <= '0;
      way_q        <= '0;
      beat_out_q   <= 1'b0;
      fresh_q      <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_out_q <= beat_out_d;
      fresh_q    <= fresh_d;
      wdata_q    <= wdata_d;
      if (bus.miss_valid && bus.miss_ready) begin
        index_q <= bus.miss_index;
        tag_q   <= bus.miss_tag;
      end
      if (state_q == StVictim) begin
        way_q        <= bus.repl_victim_way;
        victim_tag_q <= bus.victim_tag;
      end
    end
  end

endmodule
